// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: drains PS/2 set-2 bytes from a FIFO, tracks the held key and counts presses, drives hex digits.
module ps2_key_tracker #(
  parameter int CNT_W = 8,
  parameter int CNT_SAT = 0,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int BLANK_ON_RELEASE = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  ps2_data_in,
  input  logic                        ps2_ready,
  input  logic                        ps2_overflow,
  output logic                        nextdata_n,
  output logic [7:0]                  key_code,
  output logic                        key_ext,
  output logic                        key_held,
  output logic                        press_pulse,
  output logic [CNT_W-1:0]            press_count,
  output logic                        ovf_err,
  output logic [7*(2+CNT_W/4)-1:0]    hout
);
  localparam int ND = 2 + CNT_W / 4;
  localparam logic [15:0][6:0] GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  typedef enum logic [1:0] {IDLE, POP, SETTLE} state_t;
  state_t state, state_n;
  logic ext_pend, brk_pend, ext_eff, brk_eff;
  logic take, is_e0, is_f0, is_code, same, make, brk;
  logic [CNT_W+7:0] nib;
  always_comb begin
    state_n = IDLE;
    nextdata_n = 1'b1;
    if (state == IDLE) state_n = ps2_ready ? POP : IDLE;
    else if (state == POP) begin
      state_n = SETTLE;
      nextdata_n = 1'b0;
    end
  end
  // an overflow on this edge voids any pending prefix before the byte is parsed
  assign ext_eff = ext_pend & ~ps2_overflow;
  assign brk_eff = brk_pend & ~ps2_overflow;
  assign take = state == IDLE && ps2_ready;
  assign is_e0 = ps2_data_in == 8'hE0;
  assign is_f0 = ps2_data_in == 8'hF0;
  assign is_code = take && !is_e0 && !is_f0;
  assign same = key_held && {ext_eff, ps2_data_in} == {key_ext, key_code};
  assign make = is_code && !brk_eff && !same;
  assign brk = is_code && brk_eff && same;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
      key_code <= '0;
      key_ext <= 1'b0;
      key_held <= 1'b0;
      press_pulse <= 1'b0;
      press_count <= '0;
      ovf_err <= 1'b0;
    end else begin
      state <= state_n;
      ext_pend <= take ? is_e0 | (is_f0 & ext_eff) : ext_eff;
      brk_pend <= take ? is_f0 | (is_e0 & brk_eff) : brk_eff;
      press_pulse <= make;
      ovf_err <= ovf_err | ps2_overflow;
      if (make) begin
        key_code <= ps2_data_in;
        key_ext <= ext_eff;
        key_held <= 1'b1;
        press_count <= (CNT_SAT != 0 && &press_count) ? press_count : press_count + 1'b1;
      end else if (brk) key_held <= 1'b0;
    end
  end
  assign nib = {press_count, key_code};
  for (genvar i = 0; i < ND; i++) begin : g_dig
    logic [6:0] seg;
    assign seg = (i < 2 && BLANK_ON_RELEASE != 0 && !key_held) ? 7'h00 : GLYPH[nib[4*i+:4]];
    assign hout[7*i+:7] = SEG_ACTIVE_LOW != 0 ? ~seg : seg;
  end
endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Sequential successor to the keyboard display top. It drains bytes from the ps2_keyboard FIFO with a clean single-cycle pop handshake.
- Parses PS/2 set-2 make, break (F0) and extended (E0) sequences, and tracks the currently held key.
- Counts genuine key presses; typematic repeats are not counted.
- Drives a parametrised row of hex 7-seg digits: 2 for the scan code, CNT_W/4 for the press count.

Parameters:
CNT_W, 8, press counter width; must be a multiple of 4, range 4..16
CNT_SAT, 0, 0 = counter wraps to 0; 1 = counter saturates at all-ones
SEG_ACTIVE_LOW, 1, 1 = segment lit when bit is 0
BLANK_ON_RELEASE, 1, 1 = code digits blanked (all segments off) while no key held

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
ps2_data_in  input  8  FIFO head byte from ps2_keyboard
ps2_ready  input  1  FIFO non-empty
ps2_overflow  input  1  FIFO overflow flag
nextdata_n  output  1  FIFO pop, active-low, one cycle per byte
key_code  output  8  scan code of held/last key
key_ext  output  1  held/last key carried E0 prefix
key_held  output  1  a key is currently down
press_pulse  output  1  one-cycle pulse on each new press
press_count  output  CNT_W  number of new presses
ovf_err  output  1  sticky: FIFO overflow observed
hout  output  7*(2+CNT_W/4)  hex digits; digit i at hout[7i+6:7i]; digits 0-1 = key_code low/high nibble, digits 2.. = press_count nibbles, LSB first

Behaviour:
- Reset (rst=1 at posedge, highest priority, also mid-sequence):
  - nextdata_n=1; key_code=0, key_ext=0, key_held=0, press_pulse=0, press_count=0, ovf_err=0.
  - Prefix flags ext_pend and brk_pend cleared; FSM to IDLE.
  - FIFO contents are not drained.
- Pop FSM:
  - IDLE: if ps2_ready=1, latch ps2_data_in into the parser at this edge, drive nextdata_n=0 for the next cycle, go to POP.
  - POP: nextdata_n=0 this cycle only; go to SETTLE.
  - SETTLE: nextdata_n=1; ignore ps2_ready (it may be stale); go to IDLE.
  - Max throughput: 1 byte per 3 cycles. nextdata_n is never low on two consecutive cycles.
- Parser acts on the edge where a byte is latched. Byte b:
  - E0: ext_pend=1; no output change.
  - F0: brk_pend=1; no output change.
  - Other, with code = {ext_pend, b}:
    - brk_pend=1 and code equals the held code: key_held=0. key_code and key_ext retain their values.
    - brk_pend=1 and code differs from the held code, or no key held: ignored.
    - brk_pend=0, key_held=1, code equals the held code: typematic repeat. No count, no pulse.
    - brk_pend=0, otherwise: new press. key_code=b, key_ext=ext_pend, key_held=1, press_pulse=1 on the next cycle only, press_count+1.
    - Both prefix flags are cleared after any non-prefix byte.
- A new press of a different key while one is held replaces the held key (single-key tracking).
- Counter at all-ones:
  - CNT_SAT=0: wraps to 0.
  - CNT_SAT=1: stays at all-ones.
- ps2_overflow=1 on any cycle sets ovf_err (sticky until rst) and clears ext_pend and brk_pend on that edge. A byte latched on the same edge is parsed with the prefix flags cleared.
- Latency: outputs update on the same edge the byte is latched. press_pulse is high the cycle after that edge.
- hout:
  - Combinational from registered state; standard 0-F hex glyphs.
  - Polarity set by SEG_ACTIVE_LOW.
  - With BLANK_ON_RELEASE=1 and key_held=0, digits 0-1 are off.

Test Plan:
- Bytes 1C, F0, 1C -> key_code=1C, key_held 1 then 0, press_count=1, exactly one press_pulse; with SEG_ACTIVE_LOW=1 and BLANK_ON_RELEASE=1, digits 0-1 read 7'h7F after release.
- Typematic 1C,1C,1C,F0,1C -> press_count=1, one pulse, key_held=0 at end.
- Extended E0,75 then E0,F0,75 -> key_ext=1, key_code=75, key_held 1 then 0; a plain 75 after that counts as a new press with key_ext=0.
- Handshake: FIFO preloaded with 4 bytes, ps2_ready held high -> nextdata_n low for exactly 4 single cycles, each at least 3 cycles apart, no byte lost or duplicated.
- Counter boundary, CNT_W=8: 256 presses of alternating 1C/32 -> press_count=0 with CNT_SAT=0, 8'hFF with CNT_SAT=1.
- Reset/overflow: rst asserted after E0,F0 -> all outputs 0, nextdata_n=1; next byte 75 is parsed as a plain press. Separately, ps2_overflow pulsed after F0 -> ovf_err=1, and next byte 1C is treated as a make.
